// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: preamble/SFD check, payload stream out, CRC-32/length checks, frame stats.
// Latency: payload byte k leaves one cycle after byte k+D is sampled (D=5 with FCS strip, else 1).
// Backpressure: none; the output stream follows the line rate and cannot be stalled.
`timescale 1ns/1ps
module gmii_rx_mac #(
  parameter int MIN_LEN      = 64,
  parameter int MAX_LEN      = 1518,
  parameter int MIN_PREAMBLE = 7,
  parameter int STRIP_FCS    = 1,
  parameter int CNT_W        = 32
) (
  input  logic             clk_125m,
  input  logic             rst,
  input  logic             rx_dv,
  input  logic             rx_er,
  input  logic [7:0]       rxd,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             frame_done,
  output logic             frame_good,
  output logic             crc_err,
  output logic             runt_err,
  output logic             oversize_err,
  output logic             phy_err,
  output logic [15:0]      frame_len,
  output logic             pre_err,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  // Holding back the last D bytes lets the FCS be dropped without knowing the frame length up front.
  localparam int D = (STRIP_FCS != 0) ? 5 : 1;

  localparam logic [15:0] D_L        = 16'(D);
  localparam logic [15:0] MIN_LEN_L  = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN_L  = 16'(MAX_LEN);
  localparam logic [3:0]  MIN_PRE_L  = 4'(MIN_PREAMBLE);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PREAMBLE = 2'd1;
  localparam logic [1:0] S_DATA     = 2'd2;
  localparam logic [1:0] S_DROP     = 2'd3;

  logic [1:0]  state;
  logic [3:0]  pre_cnt;
  logic [15:0] len;
  logic [31:0] crc;
  logic [7:0]  dline [D];
  logic        phy_sticky;
  // Cleared by reset; set once rx_dv has been seen low, so a frame already in flight at reset release is dropped.
  logic        armed;

  logic end_crc_err;
  logic end_runt_err;
  logic end_over_err;
  logic end_good;

  // One byte of reflected CRC-32, LSB of the data byte first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // End-of-frame verdict from the state accumulated over the frame.
  always_comb begin
    end_crc_err  = (crc != CRC_RESIDUE);
    end_runt_err = (len < MIN_LEN_L) || (len < D_L);
    end_over_err = (len > MAX_LEN_L);
    end_good     = !(end_crc_err || end_runt_err || end_over_err || phy_sticky);
  end

  // Receive FSM, delay line, checks, result registers and statistics.
  always_ff @(posedge clk_125m or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      pre_cnt      <= 4'd0;
      len          <= 16'd0;
      crc          <= 32'd0;
      phy_sticky   <= 1'b0;
      armed        <= 1'b0;
      for (int i = 0; i < D; i++) dline[i] <= 8'h00;
      m_data       <= 8'h00;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      frame_done   <= 1'b0;
      frame_good   <= 1'b0;
      crc_err      <= 1'b0;
      runt_err     <= 1'b0;
      oversize_err <= 1'b0;
      phy_err      <= 1'b0;
      frame_len    <= 16'd0;
      pre_err      <= 1'b0;
      good_cnt     <= '0;
      bad_cnt      <= '0;
    end else begin
      m_valid    <= 1'b0;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      pre_err    <= 1'b0;
      if (!rx_dv) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          if (rx_dv) begin
            if (!armed) begin
              state <= S_DROP;
            end else if (rxd == 8'h55) begin
              state   <= S_PREAMBLE;
              pre_cnt <= 4'd1;
            end else begin
              state   <= S_DROP;
              pre_err <= 1'b1;
            end
          end
        end

        S_PREAMBLE: begin
          if (!rx_dv) begin
            pre_err <= 1'b1;
            state   <= S_IDLE;
          end else if (rxd == 8'h55) begin
            if (pre_cnt != 4'hF) pre_cnt <= pre_cnt + 4'd1;
          end else if (rxd == 8'hD5 && pre_cnt >= MIN_PRE_L) begin
            state      <= S_DATA;
            len        <= 16'd0;
            crc        <= 32'hFFFFFFFF;
            phy_sticky <= 1'b0;
          end else begin
            pre_err <= 1'b1;
            state   <= S_DROP;
          end
        end

        S_DATA: begin
          if (rx_dv) begin
            if (len != 16'hFFFF) len <= len + 16'd1;
            crc <= crc_byte(crc, rxd);
            if (rx_er) phy_sticky <= 1'b1;
            if (len >= D_L) begin
              m_valid <= 1'b1;
              m_data  <= dline[D-1];
            end
            for (int i = D - 1; i > 0; i--) dline[i] <= dline[i-1];
            dline[0] <= rxd;
          end else begin
            if (len >= D_L) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_data  <= dline[D-1];
            end
            frame_done   <= 1'b1;
            frame_len    <= len;
            crc_err      <= end_crc_err;
            runt_err     <= end_runt_err;
            oversize_err <= end_over_err;
            phy_err      <= phy_sticky;
            frame_good   <= end_good;
            if (end_good) begin
              if (good_cnt != '1) good_cnt <= good_cnt + 1'b1;
            end else begin
              if (bad_cnt != '1) bad_cnt <= bad_cnt + 1'b1;
            end
            for (int i = 0; i < D; i++) dline[i] <= 8'h00;
            len        <= 16'd0;
            crc        <= 32'd0;
            phy_sticky <= 1'b0;
            state      <= S_IDLE;
          end
        end

        default: begin
          if (!rx_dv) state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Bench for gmii_rx_mac: drives GMII frames into an FCS-stripping and an FCS-passing instance.
// Latency: expected bytes/results are queued at drive time and popped as the DUTs produce them.
// Backpressure: none; the monitor samples every falling edge.
`timescale 1ns/1ps
module tb_gmii_rx_mac;

  logic        clk_125m = 1'b0;
  logic        rst      = 1'b1;
  logic        rx_dv    = 1'b0;
  logic        rx_er    = 1'b0;
  logic [7:0]  rxd      = 8'h00;

  logic [7:0]  m_data;
  logic        m_valid, m_last, frame_done, frame_good;
  logic        crc_err, runt_err, oversize_err, phy_err, pre_err;
  logic [15:0] frame_len;
  logic [31:0] good_cnt, bad_cnt;

  logic [7:0]  m_data_2;
  logic        m_valid_2, m_last_2, frame_done_2, frame_good_2;
  logic        crc_err_2, runt_err_2, oversize_err_2, phy_err_2, pre_err_2;
  logic [15:0] frame_len_2;
  logic [31:0] good_cnt_2, bad_cnt_2;

  always #4 clk_125m = ~clk_125m;

  gmii_rx_mac #(.STRIP_FCS(1)) u_dut (
    .clk_125m(clk_125m), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .frame_done(frame_done), .frame_good(frame_good),
    .crc_err(crc_err), .runt_err(runt_err), .oversize_err(oversize_err), .phy_err(phy_err),
    .frame_len(frame_len), .pre_err(pre_err), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  gmii_rx_mac #(.STRIP_FCS(0)) u_dut_fcs (
    .clk_125m(clk_125m), .rst(rst), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .m_data(m_data_2), .m_valid(m_valid_2), .m_last(m_last_2),
    .frame_done(frame_done_2), .frame_good(frame_good_2),
    .crc_err(crc_err_2), .runt_err(runt_err_2), .oversize_err(oversize_err_2), .phy_err(phy_err_2),
    .frame_len(frame_len_2), .pre_err(pre_err_2), .good_cnt(good_cnt_2), .bad_cnt(bad_cnt_2)
  );

  logic [7:0]  frame_q [$];
  logic [8:0]  exp_q   [$];
  logic [8:0]  exp2_q  [$];
  logic [20:0] res_q   [$];
  int vecs = 0;
  int miss = 0;
  int done_seen = 0;
  int pre_seen = 0;
  int exp_good = 0;
  int exp_bad = 0;
  bit mute = 1'b0;
  logic [8:0]  mon_b;
  logic [20:0] mon_r;

  // Reference CRC-32 (reflected 0xEDB88320) over the payload; FCS = complement, sent LSB first.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic build_frame(input int npay, input bit corrupt);
    logic [31:0] c;
    frame_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < npay; i++) begin
      frame_q.push_back(8'(i));
      c = ref_crc(c, 8'(i));
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frame_q.push_back(c[8*i +: 8]);
    if (corrupt) frame_q[npay-1] = frame_q[npay-1] ^ 8'hFF;
  endtask

  // Queue the payload stream of both instances plus the frame verdict.
  task automatic push_expect(input bit good, input bit ce, input bit re, input bit oe, input bit pe);
    int L;
    L = frame_q.size();
    for (int k = 0; k + 4 < L; k++) exp_q.push_back({(k == L - 5), frame_q[k]});
    for (int k = 0; k < L; k++) exp2_q.push_back({(k == L - 1), frame_q[k]});
    res_q.push_back({16'(L), good, ce, re, oe, pe});
    if (good) exp_good++; else exp_bad++;
  endtask

  task automatic drive_frame(input int npre, input int bad_idx, input int er_idx, input int gap);
    for (int i = 0; i < npre; i++) begin
      @(posedge clk_125m); #1;
      rx_dv = 1'b1; rx_er = 1'b0;
      rxd = (i == bad_idx) ? 8'hAA : 8'h55;
    end
    @(posedge clk_125m); #1; rxd = 8'hD5;
    foreach (frame_q[i]) begin
      @(posedge clk_125m); #1;
      rxd = frame_q[i]; rx_er = (i == er_idx);
    end
    @(posedge clk_125m); #1;
    rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00;
    repeat (gap - 1) @(posedge clk_125m);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && (exp_q.size() + exp2_q.size() + res_q.size()) != 0; i++)
      @(negedge clk_125m);
    vecs++;
    if ((exp_q.size() + exp2_q.size() + res_q.size()) != 0) begin
      miss++;
      $display("FAIL drain: %0d/%0d bytes and %0d results still pending, required 0",
               exp_q.size(), exp2_q.size(), res_q.size());
      exp_q.delete(); exp2_q.delete(); res_q.delete();
    end
  endtask

  task automatic check_counts(input string tag);
    @(negedge clk_125m);
    vecs++;
    if (good_cnt !== 32'(exp_good) || bad_cnt !== 32'(exp_bad)) begin
      miss++;
      $display("FAIL %s counters: good=%0d bad=%0d, required good=%0d bad=%0d",
               tag, good_cnt, bad_cnt, exp_good, exp_bad);
    end
    vecs++;
    if (good_cnt_2 !== 32'(exp_good) || bad_cnt_2 !== 32'(exp_bad)) begin
      miss++;
      $display("FAIL %s counters_fcs: good=%0d bad=%0d, required good=%0d bad=%0d",
               tag, good_cnt_2, bad_cnt_2, exp_good, exp_bad);
    end
  endtask

  // Scoreboard monitor: pops expectations as the DUTs emit bytes and frame verdicts.
  always @(negedge clk_125m) begin
    if (!rst && !mute) begin
      if (m_valid) begin
        vecs++;
        if (exp_q.size() == 0) begin
          miss++;
          $display("FAIL strip_byte: unexpected byte %02h last=%0b, required none", m_data, m_last);
        end else begin
          mon_b = exp_q.pop_front();
          if ({m_last, m_data} !== mon_b) begin
            miss++;
            $display("FAIL strip_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                     m_last, m_data, mon_b[8], mon_b[7:0]);
          end
        end
      end
      if (m_valid_2) begin
        vecs++;
        if (exp2_q.size() == 0) begin
          miss++;
          $display("FAIL fcs_byte: unexpected byte %02h, required none", m_data_2);
        end else begin
          mon_b = exp2_q.pop_front();
          if ({m_last_2, m_data_2} !== mon_b) begin
            miss++;
            $display("FAIL fcs_byte: got last=%0b data=%02h, required last=%0b data=%02h",
                     m_last_2, m_data_2, mon_b[8], mon_b[7:0]);
          end
        end
      end
      if (frame_done) begin
        vecs++;
        if (res_q.size() == 0) begin
          miss++;
          $display("FAIL frame_result: unexpected frame_done len=%0d, required none", frame_len);
        end else begin
          mon_r = res_q.pop_front();
          if ({frame_len, frame_good, crc_err, runt_err, oversize_err, phy_err} !== mon_r) begin
            miss++;
            $display("FAIL frame_result: len=%0d good/crc/runt/over/phy=%0b%0b%0b%0b%0b, required len=%0d %05b",
                     frame_len, frame_good, crc_err, runt_err, oversize_err, phy_err,
                     mon_r[20:5], mon_r[4:0]);
          end
        end
      end
    end
    if (!rst) begin
      if (frame_done) done_seen++;
      if (pre_err) pre_seen++;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk_125m);
    vecs++;
    if ({m_valid, m_last, frame_done, pre_err, frame_good, crc_err, runt_err, oversize_err, phy_err} !== 9'b0
        || m_data !== 8'h00 || frame_len !== 16'h0 || good_cnt !== 32'h0 || bad_cnt !== 32'h0) begin
      miss++;
      $display("FAIL reset_state: valid=%0b done=%0b len=%0d good=%0d bad=%0d, required all 0",
               m_valid, frame_done, frame_len, good_cnt, bad_cnt);
    end
    @(posedge clk_125m); #1 rst = 1'b0;
    repeat (2) @(posedge clk_125m);
  endtask

  task automatic test_basic();
    build_frame(60, 1'b0); push_expect(1, 0, 0, 0, 0);
    drive_frame(7, -1, -1, 4);
    wait_drain(); check_counts("basic");
  endtask

  task automatic test_length_limits();
    build_frame(1514, 1'b0); push_expect(1, 0, 0, 0, 0);
    drive_frame(7, -1, -1, 4);
    build_frame(1515, 1'b0); push_expect(0, 0, 0, 1, 0);
    drive_frame(7, -1, -1, 4);
    wait_drain(); check_counts("length_limits");
  endtask

  task automatic test_crc_runt();
    build_frame(60, 1'b1); push_expect(0, 1, 0, 0, 0);
    drive_frame(8, -1, -1, 3);
    build_frame(46, 1'b0); push_expect(0, 0, 1, 0, 0);
    drive_frame(7, -1, -1, 3);
    build_frame(0, 1'b0); push_expect(0, 0, 1, 0, 0);
    drive_frame(7, -1, -1, 3);
    wait_drain(); check_counts("crc_runt");
  endtask

  task automatic test_preamble_err();
    int d0, p0;
    d0 = done_seen; p0 = pre_seen;
    build_frame(60, 1'b0);
    drive_frame(7, 3, -1, 4);
    vecs++;
    if (pre_seen - p0 !== 1) begin
      miss++;
      $display("FAIL pre_err_bad_byte: %0d pulses, required 1", pre_seen - p0);
    end
    drive_frame(5, -1, -1, 4);
    vecs++;
    if (pre_seen - p0 !== 2) begin
      miss++;
      $display("FAIL pre_err_short: %0d pulses total, required 2", pre_seen - p0);
    end
    vecs++;
    if (done_seen !== d0) begin
      miss++;
      $display("FAIL pre_err_no_done: %0d frame_done pulses, required 0", done_seen - d0);
    end
    wait_drain(); check_counts("preamble_err");
  endtask

  task automatic test_truncated();
    build_frame(60, 1'b0);
    frame_q = frame_q[0:42];
    push_expect(0, 1, 1, 0, 0);
    drive_frame(7, -1, -1, 4);
    wait_drain(); check_counts("truncated");
  endtask

  task automatic test_phy_err();
    build_frame(60, 1'b0); push_expect(0, 0, 0, 0, 1);
    drive_frame(7, -1, 10, 4);
    wait_drain(); check_counts("phy_err");
  endtask

  task automatic test_back_to_back();
    build_frame(60, 1'b0); push_expect(1, 0, 0, 0, 0);
    drive_frame(7, -1, -1, 1);
    build_frame(61, 1'b0); push_expect(1, 0, 0, 0, 0);
    drive_frame(7, -1, -1, 4);
    wait_drain(); check_counts("back_to_back");
  endtask

  task automatic test_reset_midframe();
    int d0;
    d0 = done_seen;
    mute = 1'b1;
    build_frame(60, 1'b0);
    frame_q = frame_q[0:29];
    drive_frame_open();
    @(posedge clk_125m); #1 rst = 1'b1;
    repeat (2) @(posedge clk_125m);
    #1 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_125m); #1 rxd = 8'(8'h20 + i);
    end
    @(posedge clk_125m); #1 rx_dv = 1'b0; rxd = 8'h00;
    repeat (4) @(posedge clk_125m);
    vecs++;
    if (done_seen !== d0) begin
      miss++;
      $display("FAIL reset_abort_done: %0d frame_done pulses, required 0", done_seen - d0);
    end
    mute = 1'b0;
    exp_good = 0; exp_bad = 0;
    check_counts("reset_cleared");
    build_frame(60, 1'b0); push_expect(1, 0, 0, 0, 0);
    drive_frame(7, -1, -1, 4);
    wait_drain(); check_counts("after_reset");
  endtask

  // Preamble, SFD and frame_q bytes with rx_dv left high at the end.
  task automatic drive_frame_open();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk_125m); #1; rx_dv = 1'b1; rx_er = 1'b0; rxd = 8'h55;
    end
    @(posedge clk_125m); #1 rxd = 8'hD5;
    foreach (frame_q[i]) begin
      @(posedge clk_125m); #1 rxd = frame_q[i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_length_limits();
    test_crc_runt();
    test_preamble_err();
    test_truncated();
    test_phy_err();
    test_back_to_back();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/gmii_rx_mac.md
GMII_RX_MAC -- requirements
Module: gmii_rx_mac

Interface
REQ-001 SHALL have parameter MIN_LEN, default 64, meaning minimum legal frame length in bytes (after SFD, FCS included).
REQ-002 SHALL have parameter MAX_LEN, default 1518, meaning maximum legal frame length in bytes (after SFD, FCS included).
REQ-003 SHALL have parameter MIN_PREAMBLE, default 7, meaning minimum count of consecutive 0x55 bytes required before the 0xD5 SFD.
REQ-004 SHALL have parameter STRIP_FCS, default 1, meaning 1 = FCS removed from the output stream, 0 = FCS passed through.
REQ-005 SHALL have parameter CNT_W, default 32, meaning width of the frame statistics counters.
REQ-006 SHALL have port clk_125m, input, 1 bit: single clock for all logic, GMII receive clock.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-008 SHALL have port rx_dv, input, 1 bit: GMII receive data valid.
REQ-009 SHALL have port rx_er, input, 1 bit: GMII receive error.
REQ-010 SHALL have port rxd, input, 8 bits: GMII receive data.
REQ-011 SHALL have ports m_data (output, 8 bits), m_valid (output, 1 bit) and m_last (output, 1 bit): payload byte stream, with no backpressure.
REQ-012 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-013 SHALL have port frame_good, output, 1 bit: valid with frame_done; 1 when no error flag is set.
REQ-014 SHALL have ports crc_err, runt_err, oversize_err and phy_err, outputs, 1 bit each: error flags, valid with frame_done.
REQ-015 SHALL have port frame_len, output, 16 bits: byte count after SFD, FCS included, valid with frame_done.
REQ-016 SHALL have port pre_err, output, 1 bit: one-cycle pulse on a rejected preamble.
REQ-017 SHALL have ports good_cnt and bad_cnt, outputs, CNT_W bits each: frame statistics.

Function
REQ-018 SHALL implement FSM states IDLE, PREAMBLE, DATA, DROP, with all inputs sampled on the rising edge of clk_125m.
REQ-019 IDLE: rx_dv=1 with rxd=0x55 -> PREAMBLE, preamble count=1; rx_dv=1 with any other byte -> DROP with pre_err pulse.
REQ-020 PREAMBLE: 0x55 -> count+1, saturating at 15; 0xD5 with count>=MIN_PREAMBLE -> DATA; 0xD5 with count<MIN_PREAMBLE, any other byte, or rx_dv=0 -> pre_err pulse and DROP (rx_dv=0 -> IDLE).
REQ-021 DROP: no output; stay in DROP until rx_dv=0, then IDLE; pre_err SHALL pulse once per rejected frame.
REQ-022 DATA: each rx_dv=1 cycle increments a 16-bit length counter (saturating at 0xFFFF) and updates CRC-32 (reflected polynomial 0xEDB88320, init 0xFFFFFFFF, LSB first).
REQ-023 DATA: rx_er=1 while rx_dv=1 SHALL set a sticky phy_err for the current frame.
REQ-024 Delay line depth D SHALL be 5 when STRIP_FCS=1 and 1 when STRIP_FCS=0.
REQ-025 Payload byte k SHALL appear on m_data with m_valid=1 in the cycle after byte k+D is sampled.
REQ-026 On the first rx_dv=0 cycle in DATA, the next cycle SHALL output the oldest held byte with m_valid=1 and m_last=1 (only if len>=D), assert frame_done, clear the delay line and return to IDLE.
REQ-027 If len<D, there SHALL be no m_valid for that frame; frame_done SHALL still pulse with runt_err=1.
REQ-028 crc_err SHALL be 1 when the CRC register after the final byte is not 0xDEBB20E3.
REQ-029 runt_err SHALL be 1 when len<MIN_LEN; oversize_err SHALL be 1 when len>MAX_LEN; frame_good SHALL be the NOR of all four error flags.
REQ-030 Outputs m_data, m_last, frame_len and the flags SHALL hold their last values between pulses.
REQ-031 m_valid, m_last, frame_done and pre_err SHALL be 0 except as specified above.
REQ-032 On frame_done, good_cnt SHALL increment when frame_good=1, else bad_cnt SHALL increment; both saturate at all-ones.
REQ-033 A new frame starting the cycle immediately after rx_dv falls SHALL be accepted normally.

Reset
REQ-034 While rst=1, all outputs and counters SHALL be 0, the FSM SHALL be in IDLE, and the CRC, length and delay line SHALL be cleared.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no frame_done; after release, a frame arriving while rx_dv is already high SHALL go to DROP until rx_dv=0.

Verification
REQ-036 7x0x55, 0xD5, payload 0..59, valid FCS -> 60 m_valid bytes 0x00..0x3B, m_last on 0x3B, frame_len=64, frame_good=1, good_cnt=1.
REQ-037 1514-byte payload with valid FCS -> frame_len=1518, frame_good=1; 1515-byte payload -> frame_len=1519, oversize_err=1, bad_cnt increments.
REQ-038 60-byte payload with last payload byte XOR 0xFF -> crc_err=1, frame_good=0; 46-byte payload -> frame_len=50, runt_err=1.
REQ-039 Preamble byte 3 = 0xAA -> pre_err one pulse, no m_valid, no frame_done, counters unchanged.
REQ-040 Frame truncated to 51 bytes total (43 after SFD) -> frame_len=43, runt_err=1, crc_err=1.
REQ-041 rst pulse mid-payload, then a clean 64-byte frame -> no frame_done for the aborted frame, then good_cnt=1.
REQ-042 STRIP_FCS=0 build -> 64 m_valid bytes per 64-byte frame, m_last on the last FCS byte.
